// File: rtl/fb_read_scanner_if.sv
// fb_read_scanner_if: RAM read port plus pixel stream.
// master = scanner side, slave = RAM and display driver side.
interface fb_read_scanner_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] o_ram_addr;
   logic              o_ram_r_en;
   logic [DATA_W-1:0] i_ram_data;
   logic [DATA_W-1:0] o_pix_data;
   logic              o_pix_valid;
   logic              i_pix_ready;

   modport master (
      output o_ram_addr,
      output o_ram_r_en,
      input  i_ram_data,
      output o_pix_data,
      output o_pix_valid,
      input  i_pix_ready
   );

   modport slave (
      input  o_ram_addr,
      input  o_ram_r_en,
      output i_ram_data,
      input  o_pix_data,
      input  o_pix_valid,
      output i_pix_ready
   );
endinterface

// File: rtl/fb_read_scanner.sv
// fb_read_scanner: sweeps the framebuffer RAM one byte at a time and
// delivers each byte to the display driver, paced or by handshake.
// Ports: clk, rst_n (async, active-low); i_enable, i_mode, i_pace,
// i_scroll, i_restart controls; bus = RAM read port + pixel stream;
// o_frame_start / o_frame_done pulses; o_busy when not IDLE.
module fb_read_scanner #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 8,
   parameter int FB_DEPTH     = 1024,
   parameter int READ_LATENCY = 1,
   parameter int PACE_W       = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_mode,
   input  logic [PACE_W-1:0] i_pace,
   input  logic [ADDR_W-1:0] i_scroll,
   input  logic              i_restart,
   fb_read_scanner_if.master bus,
   output logic              o_frame_start,
   output logic              o_frame_done,
   output logic              o_busy
);

   localparam int LAT_W = $clog2(READ_LATENCY + 1);
   localparam int MIN_W = $clog2(READ_LATENCY + 2);
   localparam int CNT_W = ((PACE_W > MIN_W) ? PACE_W : MIN_W) + 1;

   localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_LO = ADDR_W'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(FB_DEPTH - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0]  MIN_LAST = CNT_W'(READ_LATENCY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_PRESENT,
      S_GAP
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] off_q;
   logic [LAT_W-1:0]  wcnt_q;
   logic [CNT_W-1:0]  pcnt_q;
   logic [CNT_W-1:0]  plast_q;
   logic              mode_q;
   logic              rflag_q;
   logic [DATA_W-1:0] pix_q;

   logic [ADDR_W-1:0] scroll_c;
   logic [ADDR_W-1:0] eff_off;
   logic [ADDR_W:0]   sum;
   logic              wrap;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  pace_last;
   logic [ADDR_W-1:0] idx_nxt;
   logic              wait_last;
   logic              period_end;
   logic              deliver;
   logic              restart_now;

   // Out-of-range scroll falls back to no offset.
   assign scroll_c = ({1'b0, i_scroll} >= DEPTH) ? '0 : i_scroll;

   // The offset is taken live on the first fetch of a frame, so
   // address 0 of the new frame already sees the new scroll.
   assign eff_off = (state_q == S_FETCH && idx_q == '0)
                    ? scroll_c : off_q;

   assign sum  = {1'b0, idx_q} + {1'b0, eff_off};
   assign wrap = (sum >= DEPTH);
   assign addr = wrap ? (sum[ADDR_W-1:0] - DEPTH_LO)
                      : sum[ADDR_W-1:0];

   // Last counter value of a paced period: max(pace, latency+1).
   assign pace_last = (CNT_W'(i_pace) > MIN_LAST)
                      ? CNT_W'(i_pace) : MIN_LAST;

   assign idx_nxt     = (idx_q == LAST) ? '0 : idx_q + 1'b1;
   assign wait_last   = (wcnt_q == LAT_LAST);
   assign period_end  = (pcnt_q == plast_q);
   assign restart_now = rflag_q | i_restart;

   assign deliver = (state_q == S_PRESENT) &&
                    (!mode_q || bus.i_pix_ready);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_enable) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_last) state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (deliver) begin
               if (mode_q || period_end)
                  state_d = i_enable ? S_FETCH : S_IDLE;
               else
                  state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (period_end)
               state_d = i_enable ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         off_q   <= '0;
         wcnt_q  <= '0;
         pcnt_q  <= '0;
         plast_q <= '0;
         mode_q  <= 1'b0;
         rflag_q <= 1'b0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;

         // Mode and pace only change at a fetch.
         if (state_q == S_FETCH) begin
            mode_q  <= i_mode;
            plast_q <= pace_last;
            if (idx_q == '0) off_q <= scroll_c;
         end

         if (state_q == S_FETCH)
            wcnt_q <= '0;
         else if (state_q == S_WAIT)
            wcnt_q <= wcnt_q + 1'b1;

         if (state_d == S_FETCH)
            pcnt_q <= '0;
         else if (state_q != S_IDLE)
            pcnt_q <= pcnt_q + 1'b1;

         if (state_q == S_WAIT && wait_last)
            pix_q <= bus.i_ram_data;

         // A pending restart wins over the increment of the
         // byte just delivered.
         if (state_d == S_FETCH && restart_now)
            idx_q <= '0;
         else if (deliver)
            idx_q <= idx_nxt;

         if (state_d == S_FETCH)
            rflag_q <= 1'b0;
         else if (i_restart)
            rflag_q <= 1'b1;
      end
   end

   assign bus.o_ram_addr  = addr;
   assign bus.o_ram_r_en  = (state_q == S_FETCH);
   assign bus.o_pix_data  = pix_q;
   assign bus.o_pix_valid = (state_q == S_PRESENT);

   assign o_frame_start = (state_q == S_FETCH) && (idx_q == '0);
   // A restart already pending when the last byte goes out marks a
   // truncated frame; one arriving on that very cycle does not.
   assign o_frame_done  = deliver && (idx_q == LAST) && !rflag_q;
   assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fb_read_scanner.sv
// tb_fb_read_scanner: directed tests for fb_read_scanner.
// RAM model returns the low address byte one cycle after a read.
module tb_fb_read_scanner;
   localparam int AW    = 14;
   localparam int DW    = 8;
   localparam int DEPTH = 1024;
   localparam int RL    = 1;
   localparam int PW    = 5;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          en      = 1'b0;
   logic          mode    = 1'b0;
   logic [PW-1:0] pace    = '0;
   logic [AW-1:0] scroll  = '0;
   logic          restart = 1'b0;
   logic          fs;
   logic          fd;
   logic          busy;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int cur_addr = 0;

   int fq_cyc[$];
   int fq_addr[$];
   bit fq_fs[$];
   int dq_cyc[$];
   int dq_data[$];
   int dn_addr[$];

   fb_read_scanner_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fb_read_scanner #(
      .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH),
      .READ_LATENCY(RL), .PACE_W(PW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_enable(en),
      .i_mode(mode),
      .i_pace(pace),
      .i_scroll(scroll),
      .i_restart(restart),
      .bus(bus),
      .o_frame_start(fs),
      .o_frame_done(fd),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (bus.o_ram_r_en) bus.i_ram_data <= bus.o_ram_addr[7:0];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_ram_r_en) begin
            fq_cyc.push_back(cyc);
            fq_addr.push_back(int'(bus.o_ram_addr));
            fq_fs.push_back(fs);
            cur_addr <= int'(bus.o_ram_addr);
         end
         if (bus.o_pix_valid && (!mode || bus.i_pix_ready)) begin
            dq_cyc.push_back(cyc);
            dq_data.push_back(int'(bus.o_pix_data));
         end
         if (fd) dn_addr.push_back(cur_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      fq_cyc.delete();
      fq_addr.delete();
      fq_fs.delete();
      dq_cyc.delete();
      dq_data.delete();
      dn_addr.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      mode = 1'b0;
      pace = '0;
      scroll = '0;
      restart = 1'b0;
      bus.i_pix_ready = 1'b0;
      step();
      step();
      clear_log();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_fetch(input int n, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (fq_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b0;
      bus.i_pix_ready = 1'b0;
      #1;
      n_chk++;
      if ({bus.o_ram_r_en, bus.o_pix_valid, fs, fd, busy} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.o_ram_r_en, bus.o_pix_valid, fs, fd, busy});
      else n_pass++;
      n_chk++;
      if (bus.o_pix_data !== 8'h00)
         $display("FAIL reset_data: got %h want 00", bus.o_pix_data);
      else n_pass++;
      n_chk++;
      if (bus.o_ram_addr !== 14'd0)
         $display("FAIL reset_addr: got %0d want 0", bus.o_ram_addr);
      else n_pass++;
      step();
      clear_log();
      rst_n = 1'b1;
      repeat (4) step();
      n_chk++;
      if (busy !== 1'b0 || fq_cyc.size() != 0)
         $display("FAIL idle_hold: busy %b fetches %0d want 0 0",
                  busy, fq_cyc.size());
      else n_pass++;
   endtask

   task automatic test_paced_sweep();
      bit ok;
      int k, e_int, e_addr, e_data, nfs, da;
      do_reset();
      pace = 5'd17;
      en = 1'b1;
      k = cyc;
      wait_fetch(1026, 20000, ok);
      n_chk++;
      if (!ok) $display("FAIL sweep_timeout: got %0d want 1026",
                        fq_cyc.size());
      else n_pass++;
      if (ok) begin
         n_chk++;
         if (fq_cyc[0] != k + 1)
            $display("FAIL en_latency: got %0d want %0d",
                     fq_cyc[0] - k, 1);
         else n_pass++;
         n_chk++;
         if (dq_cyc[0] - fq_cyc[0] != RL + 1)
            $display("FAIL data_latency: got %0d want %0d",
                     dq_cyc[0] - fq_cyc[0], RL + 1);
         else n_pass++;
         e_int = 0; e_addr = 0; e_data = 0; nfs = 0;
         for (int i = 0; i < 1026; i++) begin
            if (i < 1025 && fq_cyc[i+1] - fq_cyc[i] != 18) e_int++;
            if (fq_addr[i] != i % 1024) e_addr++;
            if (fq_fs[i]) nfs++;
         end
         for (int i = 0; i < 1025; i++)
            if (dq_data[i] != (i % 1024) % 256) e_data++;
         n_chk++;
         if (e_int != 0)
            $display("FAIL sweep_period: got %0d bad want 0", e_int);
         else n_pass++;
         n_chk++;
         if (e_addr != 0)
            $display("FAIL sweep_addr: got %0d bad want 0", e_addr);
         else n_pass++;
         n_chk++;
         if (e_data != 0)
            $display("FAIL sweep_data: got %0d bad want 0", e_data);
         else n_pass++;
         n_chk++;
         if (nfs != 2)
            $display("FAIL sweep_fstart: got %0d want 2", nfs);
         else n_pass++;
         da = (dn_addr.size() > 0) ? dn_addr[0] : -1;
         n_chk++;
         if (dn_addr.size() != 1 || da != 1023)
            $display("FAIL sweep_fdone: got n=%0d a=%0d want 1 1023",
                     dn_addr.size(), da);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_pace_clamp();
      bit ok;
      int e_int, e_data;
      do_reset();
      pace = 5'd0;
      en = 1'b1;
      wait_fetch(10, 100, ok);
      n_chk++;
      if (!ok) $display("FAIL clamp_timeout: got %0d want 10",
                        fq_cyc.size());
      else n_pass++;
      if (ok) begin
         e_int = 0; e_data = 0;
         for (int i = 0; i < 9; i++)
            if (fq_cyc[i+1] - fq_cyc[i] != RL + 2) e_int++;
         for (int i = 0; i < 8; i++)
            if (dq_data[i] != i) e_data++;
         n_chk++;
         if (e_int != 0)
            $display("FAIL clamp_period: got %0d bad want 0", e_int);
         else n_pass++;
         n_chk++;
         if (e_data != 0)
            $display("FAIL clamp_data: got %0d bad want 0", e_data);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_scroll_wrap();
      bit ok;
      int e_addr, e_data, da;
      do_reset();
      pace = 5'd2;
      scroll = 14'd1000;
      en = 1'b1;
      wait_fetch(10, 100, ok);
      scroll = 14'd5;
      wait_fetch(1026, 4000, ok);
      n_chk++;
      if (!ok) $display("FAIL scroll_timeout: got %0d want 1026",
                        fq_cyc.size());
      else n_pass++;
      if (ok) begin
         e_addr = 0; e_data = 0;
         for (int i = 0; i < 1024; i++) begin
            if (fq_addr[i] != (1000 + i) % 1024) e_addr++;
            if (dq_data[i] != ((1000 + i) % 1024) % 256) e_data++;
         end
         n_chk++;
         if (e_addr != 0)
            $display("FAIL scroll_addr: got %0d bad want 0", e_addr);
         else n_pass++;
         n_chk++;
         if (e_data != 0)
            $display("FAIL scroll_data: got %0d bad want 0", e_data);
         else n_pass++;
         n_chk++;
         if (fq_addr[1024] != 5 || fq_fs[1024] != 1'b1)
            $display("FAIL scroll_next: got a=%0d fs=%0d want 5 1",
                     fq_addr[1024], fq_fs[1024]);
         else n_pass++;
         da = (dn_addr.size() > 0) ? dn_addr[0] : -1;
         n_chk++;
         if (dn_addr.size() != 1 || da != 999)
            $display("FAIL scroll_fdone: got n=%0d a=%0d want 1 999",
                     dn_addr.size(), da);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_handshake_stall();
      bit ok;
      int vcnt, errs, e_int, e_data;
      logic [DW-1:0] d0;
      logic nxt_fetch;
      do_reset();
      mode = 1'b1;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_pix_valid) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!ok) $display("FAIL hs_valid_timeout: got 0 want 1");
      else n_pass++;
      d0 = bus.o_pix_data;
      vcnt = 1;
      errs = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.o_pix_valid) vcnt++;
         if (bus.o_pix_data !== d0 || bus.o_ram_r_en !== 1'b0) errs++;
      end
      step();
      bus.i_pix_ready = 1'b1;
      @(negedge clk);
      if (bus.o_pix_valid) vcnt++;
      @(negedge clk);
      nxt_fetch = bus.o_ram_r_en;
      n_chk++;
      if (d0 !== 8'h00)
         $display("FAIL hs_first_data: got %h want 00", d0);
      else n_pass++;
      n_chk++;
      if (errs != 0)
         $display("FAIL hs_stall_stable: got %0d bad want 0", errs);
      else n_pass++;
      n_chk++;
      if (vcnt != 6)
         $display("FAIL hs_valid_len: got %0d want 6", vcnt);
      else n_pass++;
      n_chk++;
      if (nxt_fetch !== 1'b1)
         $display("FAIL hs_next_fetch: got %b want 1", nxt_fetch);
      else n_pass++;
      wait_fetch(5, 40, ok);
      n_chk++;
      if (!ok) $display("FAIL hs_timeout: got %0d want 5",
                        fq_cyc.size());
      else n_pass++;
      if (ok) begin
         n_chk++;
         if (fq_cyc[1] - fq_cyc[0] != 8)
            $display("FAIL hs_stall_gap: got %0d want 8",
                     fq_cyc[1] - fq_cyc[0]);
         else n_pass++;
         e_int = 0; e_data = 0;
         for (int i = 1; i < 4; i++)
            if (fq_cyc[i+1] - fq_cyc[i] != RL + 2) e_int++;
         for (int i = 0; i < 4; i++)
            if (dq_data[i] != i) e_data++;
         n_chk++;
         if (e_int != 0)
            $display("FAIL hs_throughput: got %0d bad want 0", e_int);
         else n_pass++;
         n_chk++;
         if (e_data != 0)
            $display("FAIL hs_data: got %0d bad want 0", e_data);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_disable_mid_frame();
      bit ok;
      do_reset();
      mode = 1'b1;
      bus.i_pix_ready = 1'b1;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (fq_addr.size() > 0 && fq_addr[$] == 37) begin
            ok = 1'b1;
            break;
         end
      end
      en = 1'b0;
      n_chk++;
      if (!ok) $display("FAIL dis_reach_37: got %0d want 38",
                        fq_addr.size());
      else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!ok) $display("FAIL dis_idle_timeout: got busy 1 want 0");
      else n_pass++;
      n_chk++;
      if (dq_data.size() != 38 || (ok && dq_data[$] != 37))
         $display("FAIL dis_last_byte: got n=%0d want 38 (data 37)",
                  dq_data.size());
      else n_pass++;
      repeat (5) step();
      n_chk++;
      if (busy !== 1'b0 || fq_addr.size() != 38)
         $display("FAIL dis_hold: got busy %b fetches %0d want 0 38",
                  busy, fq_addr.size());
      else n_pass++;
      en = 1'b1;
      wait_fetch(39, 10, ok);
      n_chk++;
      if (!ok || fq_addr[38] != 38 || fq_fs[38] != 1'b0)
         $display("FAIL dis_resume: got n=%0d want idx 38 no fstart",
                  fq_addr.size());
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_restart();
      bit ok;
      int j, nfs;
      do_reset();
      mode = 1'b1;
      bus.i_pix_ready = 1'b1;
      scroll = 14'd7;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (fq_addr.size() > 0 && fq_addr[$] == 507) begin
            ok = 1'b1;
            break;
         end
      end
      restart = 1'b1;
      step();
      restart = 1'b0;
      n_chk++;
      if (!ok) $display("FAIL rs_reach_500: got %0d want 501",
                        fq_addr.size());
      else n_pass++;
      j = fq_addr.size() - 1;
      wait_fetch(j + 3, 20, ok);
      if (ok) begin
         n_chk++;
         if (dq_data[j] != 8'hFB)
            $display("FAIL rs_inflight: got %0d want %0d",
                     dq_data[j], 8'hFB);
         else n_pass++;
         n_chk++;
         if (fq_addr[j+1] != 7 || fq_fs[j+1] != 1'b1)
            $display("FAIL rs_next: got a=%0d fs=%0d want 7 1",
                     fq_addr[j+1], fq_fs[j+1]);
         else n_pass++;
         n_chk++;
         if (fq_addr[j+2] != 8)
            $display("FAIL rs_follow: got %0d want 8", fq_addr[j+2]);
         else n_pass++;
      end
      nfs = 0;
      foreach (fq_fs[i]) if (fq_fs[i]) nfs++;
      n_chk++;
      if (!ok || nfs != 2 || dn_addr.size() != 0)
         $display("FAIL rs_pulses: got fs=%0d fd=%0d want 2 0",
                  nfs, dn_addr.size());
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_reset_present();
      bit ok;
      logic [DW-1:0] dpre;
      do_reset();
      pace = 5'd5;
      en = 1'b1;
      wait_fetch(6, 100, ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.o_pix_valid) begin
            ok = 1'b1;
            break;
         end
      end
      dpre = bus.o_pix_data;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (!ok || dpre !== 8'd5)
         $display("FAIL rp_present: got %h want 05", dpre);
      else n_pass++;
      n_chk++;
      if ({bus.o_ram_r_en, bus.o_pix_valid, fs, fd, busy} !== 5'b0 ||
          bus.o_pix_data !== 8'h00)
         $display("FAIL rp_async: got %b/%h want 00000/00",
                  {bus.o_ram_r_en, bus.o_pix_valid, fs, fd, busy},
                  bus.o_pix_data);
      else n_pass++;
      clear_log();
      step();
      step();
      rst_n = 1'b1;
      wait_fetch(2, 20, ok);
      n_chk++;
      if (!ok || fq_addr[0] != 0 || fq_fs[0] != 1'b1 || fq_addr[1] != 1)
         $display("FAIL rp_restart_sweep: got n=%0d want 0,1 fstart",
                  fq_addr.size());
      else n_pass++;
      en = 1'b0;
   endtask

   initial begin
      bus.i_pix_ready = 1'b0;
      test_reset();
      test_paced_sweep();
      test_pace_clamp();
      test_scroll_wrap();
      test_handshake_stall();
      test_disable_mid_frame();
      test_restart();
      test_reset_present();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fb_read_scanner.md
# fb_read_scanner

Parametrised framebuffer read scanner. It sweeps the display RAM read port, fetches one pixel byte at a time, and delivers it to the display driver, either at a programmable pace or over a valid/ready handshake. It replaces the hard-wired fixed-period address counter between RAM and the OLED driver, and adds a scroll offset, frame pulses, a restart, and clean pause/resume.

## Interface
- `ADDR_W`, 14: RAM address width.
- `DATA_W`, 8: pixel byte width.
- `FB_DEPTH`, 1024: bytes per frame; must satisfy `FB_DEPTH <= 2**ADDR_W`.
- `READ_LATENCY`, 1: RAM cycles from `o_ram_r_en` to valid `i_ram_data`; must be at least 1.
- `PACE_W`, 5: width of `i_pace`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `i_enable`  in  1: consumer wants data; level-sensitive.
- `i_mode`  in  1: 0 = PACED, 1 = HANDSHAKE; sampled only at byte boundaries.
- `i_pace`  in  PACE_W: PACED byte period minus 1, in cycles.
- `i_scroll`  in  ADDR_W: start offset, latched at frame start; values `>= FB_DEPTH` are treated as 0.
- `i_restart`  in  1: one-cycle pulse; the next fetch is index 0.
- `o_ram_addr`  out  ADDR_W: RAM read address.
- `o_ram_r_en`  out  1: RAM read strobe.
- `i_ram_data`  in  DATA_W: RAM read data.
- `o_pix_data`  out  DATA_W: registered pixel byte.
- `o_pix_valid`  out  1: `o_pix_data` is valid.
- `i_pix_ready`  in  1: consumer accepts data (HANDSHAKE mode only).
- `o_frame_start`  out  1: one-cycle pulse when index 0 is fetched.
- `o_frame_done`  out  1: one-cycle pulse when index `FB_DEPTH-1` is delivered.
- `o_busy`  out  1: high whenever the state is not IDLE.

## Operation
- **State machine states:** IDLE, FETCH, WAIT, PRESENT, GAP.
- **Address generation:**
  - `idx` counts 0..`FB_DEPTH-1`.
  - `o_ram_addr = idx + off`, minus `FB_DEPTH` if the sum is `>= FB_DEPTH`. The sum is computed at `ADDR_W+1` bits, so there is no overflow.
  - `off` is latched from `i_scroll` in the FETCH cycle of `idx = 0`.
- **IDLE → FETCH:** when `i_enable` = 1.
- **FETCH:** lasts 1 cycle. `o_ram_r_en` = 1 and `o_ram_addr` is driven. `o_frame_start` = 1 if `idx = 0`. Then go to WAIT.
- **WAIT:** lasts `READ_LATENCY` cycles. On the last cycle, capture `i_ram_data` into `o_pix_data`. Then go to PRESENT.
- **PRESENT:** `o_pix_valid` = 1.
  - PACED: lasts 1 cycle.
  - HANDSHAKE: held until `i_pix_ready` = 1; the transfer occurs in that cycle.
  - On exit, the byte is delivered. `idx` increments and wraps from `FB_DEPTH-1` to 0. `o_frame_done` pulses on the same cycle if the delivered `idx` was `FB_DEPTH-1`.
- **After PRESENT:**
  - PACED: go to GAP until the period counter reaches `P-1`.
  - HANDSHAKE: go directly to the boundary decision.
- **Boundary decision:** `i_enable` = 1 → FETCH; `i_enable` = 0 → IDLE.
- **PACED period:**
  - `P = max(i_pace+1, READ_LATENCY+2)`.
  - The period counter is cleared on FETCH entry.
  - A fetch occurs exactly every `P` cycles while enabled.
- **Disable mid-byte:** the byte in flight completes, including a HANDSHAKE stall. Then the block goes to IDLE with `idx` and `off` retained, and resumes at the same `idx`.
- **Restart:**
  - `i_restart` sets a sticky flag.
  - At the next boundary or IDLE exit, `idx` is forced to 0 and the flag clears.
  - Restart does not abort a byte in flight, and it suppresses `o_frame_done` for the truncated frame.
  - If restart coincides with delivery of `idx = FB_DEPTH-1`, `o_frame_done` still pulses.

## Timing
- **Reset values:** all outputs 0, state IDLE, `idx` 0, `off` 0, restart flag 0.
- **Asynchronous reset:** any state returns to IDLE immediately. `o_pix_valid` drops asynchronously, and a pending RAM read is discarded.
- **Enable latency:** the first `o_ram_r_en` occurs 1 cycle after `i_enable` rises in IDLE (registered decision).
- **Data latency:** `o_pix_valid` rises `READ_LATENCY+1` cycles after the FETCH cycle.
- **HANDSHAKE throughput:** with `ready` held at 1, one byte per `READ_LATENCY+2` cycles.
- **Stall behaviour:** while `o_pix_valid`=1 and `i_pix_ready`=0, `o_pix_data` is stable and `o_ram_r_en` = 0.
- **Mode and pace changes:** `i_mode` and `i_pace` changes take effect at the next FETCH only.

## Test plan
- **PACED sweep:** PACED, `i_pace`=17, `i_scroll`=0, `i_enable`=1, RAM[a]=a[7:0] → `o_ram_r_en` every 18 cycles. Addresses run 0..1023 then 0. Data matches the address low byte. `o_frame_start` and `o_frame_done` pulse once per 1024 bytes.
- **Pace clamp:** PACED, `i_pace`=0, `READ_LATENCY`=1 → period clamped to 3 cycles, one byte per 3 cycles.
- **Scroll wrap:** `i_scroll`=1000 → addresses 1000..1023, 0..999. `o_frame_done` occurs on address 999. Changing `i_scroll` mid-frame has no effect until the next frame.
- **HANDSHAKE stall:** HANDSHAKE, `ready` low for 5 cycles after valid → valid held 6 cycles, data stable, no fetch during the stall. The next fetch occurs the cycle after acceptance.
- **Disable mid-frame:** drop `i_enable` during WAIT at `idx`=37 → byte 37 is delivered, then IDLE with `o_busy`=0. Re-enabling fetches idx 38.
- **Restart and reset:** restart pulse at `idx`=500 → the next fetch is address `off+0` with `o_frame_start` and no `o_frame_done`. `rst_n` low during PRESENT → all outputs 0 immediately, and after release the sweep starts from address 0.
